pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Reset sequencer and lock supervisor for the system PLL (50 MHz reference in, two 96 MHz outputs, the second phase-shifted for SDRAM).
- Pulses the PLL reset after power-up and waits for a stable `locked`.
- Releases the downstream system reset only once lock is stable.
- Re-sequences the PLL on lock loss, lock timeout or host request, with bounded retries and a sticky fault.
- Runs entirely on the reference clock, because PLL outputs are not trustworthy before lock.

## Interface
Parameters:
- `RST_CYCLES`, 32, cycles `pll_rst` is held high per sequence (≥2)
- `LOCK_STABLE`, 1024, consecutive synchronized-locked cycles required before release
- `LOCK_TIMEOUT`, 1048576, cycles allowed from `pll_rst` release to reaching RUN
- `MAX_RETRY`, 3, timeout retries before FAULT (1..3)

Ports:
- `refclk` in 1: 50 MHz reference clock; sole clock of the block
- `rst_n` in 1: asynchronous active-low reset
- `pll_locked` in 1: raw PLL `locked`, asynchronous to `refclk`
- `force_relock` in 1: synchronous single-cycle request to re-sequence the PLL
- `pll_rst` out 1: PLL reset, active high
- `sys_rst` out 1: downstream reset, active high; consumers synchronize it into their own domains
- `ready` out 1: PLL locked and stable, `sys_rst` released
- `fault` out 1: retries exhausted
- `retry_cnt` out 2: timeouts in the current sequence
- `lock_lost` out 1: sticky; lock dropped while in RUN

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`; all decisions use `locked_s`.
- FSM states are RESET_PLL, WAIT_LOCK, STABLE, RUN and FAULT. The FSM enters RESET_PLL when `rst_n` releases.
- RESET_PLL: `pll_rst`=1 for exactly `RST_CYCLES` cycles, then go to WAIT_LOCK. Entry clears the timeout counter.
- WAIT_LOCK: `pll_rst`=0 and the timeout counter runs. `locked_s`=1 goes to STABLE with the stable counter at 0.
- STABLE: the stable counter increments while `locked_s`=1. `locked_s`=0 returns to WAIT_LOCK, and the timeout counter is not cleared. Reaching `LOCK_STABLE` goes to RUN.
- The timeout counter runs in both WAIT_LOCK and STABLE. On reaching `LOCK_TIMEOUT`:
  - `retry_cnt`==`MAX_RETRY` goes to FAULT;
  - otherwise `retry_cnt` increments and the FSM goes to RESET_PLL.
- RUN: `ready`=1, `sys_rst`=0, `retry_cnt` cleared to 0. A lock loss sets `lock_lost` and goes to RESET_PLL; it does not increment `retry_cnt`.
- FAULT: `fault`=1, `pll_rst`=0, `sys_rst`=1. Exit only via `rst_n` or `force_relock`.
- `force_relock` from any state except RESET_PLL goes to RESET_PLL and clears `retry_cnt` and `fault`.
  - It is ignored in RESET_PLL; the pulse counter is not restarted.
  - Same cycle as a timeout or lock loss: `force_relock` wins and `retry_cnt` ends at 0. `lock_lost` is still set if the FSM was in RUN.
- `sys_rst`=1 in every state except RUN.
- Counter widths are `$clog2` of the parameter plus 1. Counters saturate and do not wrap.

## Timing
- Outputs while `rst_n`=0 (asynchronous): `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0, `lock_lost`=0.
- All outputs are registered and change only on the `refclk` rising edge.
- `pll_rst` falls `RST_CYCLES` edges after the first edge following `rst_n` release.
- Synchronizer latency: a `pll_locked` edge is seen by the FSM 2 cycles later.
- `pll_locked` rising to `ready` rising takes 2 + 1 + `LOCK_STABLE` cycles, given no dropouts.
- `ready` rises and `sys_rst` falls on the same edge.
- A RUN lock loss (`pll_locked` falling) drops `ready`, raises `sys_rst` and raises `pll_rst` 3 edges later (2 synchronizer + 1 FSM; +4 with the filter below).
- `force_relock` sampled high raises `pll_rst` and `sys_rst` on the next edge.

## Configuration
- Macro `PLL_SUP_LOSS_FILTER_EN`.
- Defined: in RUN, `locked_s` must be low for 4 consecutive cycles before a loss is declared. Shorter dropouts are ignored, and `lock_lost` is not set.
- Undefined: a single low cycle of `locked_s` in RUN is a loss.
- The filter applies in RUN only. STABLE keeps its single-cycle reaction in both builds.

## Test plan
Bench parameters: `RST_CYCLES`=4, `LOCK_STABLE`=8, `LOCK_TIMEOUT`=64, `MAX_RETRY`=2.
- Power-up, `pll_locked` rises 10 cycles after `pll_rst` falls: `pll_rst` high for 4 cycles; `ready`=1 and `sys_rst`=0 exactly 11 cycles after `pll_locked` rises.
- `pll_locked` stays 0: three `pll_rst` pulses with `retry_cnt` going 0, 1, 2, then `fault`=1 at 64 cycles after the third release, with `pll_rst` held 0.
- In FAULT, pulse `force_relock`: `fault`=0, `retry_cnt`=0, `pll_rst` high for 4 cycles, normal sequence resumes.
- `pll_locked` drops for 1 cycle in STABLE at count 5: returns to WAIT_LOCK, the stable count restarts, and `ready` is delayed accordingly. Timeout still measured from the original release.
- In RUN, drop `pll_locked` for 2 cycles:
  - without the macro: `lock_lost`=1, `ready`=0, `pll_rst`=1 after 3 cycles, `retry_cnt` stays 0;
  - with `PLL_SUP_LOSS_FILTER_EN`: no effect. A 5-cycle drop triggers re-sequencing.
- Assert `rst_n`=0 mid-STABLE, asynchronously: all outputs take reset values immediately, and a full sequence follows release.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Reset sequencer and lock supervisor for the system PLL.
//               Pulses the PLL reset, waits for a stable synchronized lock,
//               releases the downstream reset, and re-sequences on lock loss,
//               lock timeout or host request with bounded retries.
//               Runs entirely on the reference clock.
//               Optional macro PLL_SUP_LOSS_FILTER_EN: in RUN, require four
//               consecutive low cycles of synchronized lock before a loss.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int RST_CYCLES   = 32,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int MAX_RETRY    = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic       lock_lost
);

    localparam int RST_W = $clog2(RST_CYCLES) + 1;
    localparam int STB_W = $clog2(LOCK_STABLE) + 1;
    localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [RST_W-1:0] c_rst_last  = RST_W'(RST_CYCLES);
    localparam logic [STB_W-1:0] c_stb_last  = STB_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0]  c_to_last   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]       c_max_retry = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [1:0]         retry_q, retry_d;
    logic               lost_q, lost_d;
    logic               pll_rst_q, sys_rst_q, ready_q, fault_q;

    logic               w_locked_s;
    logic               w_timeout;
    logic               w_loss;

    assign w_locked_s = sync_q[1];
    assign w_timeout  = (to_cnt_q == c_to_last);

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

`ifdef PLL_SUP_LOSS_FILTER_EN
    logic [2:0] low_cnt_q, low_cnt_d;

    // Count consecutive low lock samples while running, saturating at four
    always_comb begin
        low_cnt_d = 3'd0;
        if (state_q == RUN && !w_locked_s) begin
            low_cnt_d = (low_cnt_q == 3'd4) ? low_cnt_q : low_cnt_q + 3'd1;
        end
    end

    // Dropout filter counter register
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt_q <= 3'd0;
        end else begin
            low_cnt_q <= low_cnt_d;
        end
    end

    // Loss declared one cycle after the fourth consecutive low sample
    assign w_loss = (state_q == RUN) && (low_cnt_q == 3'd4);
`else
    assign w_loss = (state_q == RUN) && !w_locked_s;
`endif

    // Next-state and counter logic; host request overrides everything but an active pulse
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        stb_cnt_d = stb_cnt_q;
        to_cnt_d  = to_cnt_q;
        retry_d   = retry_q;
        lost_d    = lost_q;

        case (state_q)
            RESET_PLL: begin
                if (rst_cnt_q == c_rst_last) begin
                    state_d = WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (w_timeout) begin
                    if (retry_q == c_max_retry) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = RESET_PLL;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (w_locked_s) begin
                        state_d   = STABLE;
                        stb_cnt_d = '0;
                    end
                end
            end
            STABLE: begin
                // Reaching the stable count within the window takes precedence
                if (w_locked_s && stb_cnt_q == c_stb_last) begin
                    state_d = RUN;
                end else if (w_timeout) begin
                    if (retry_q == c_max_retry) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = RESET_PLL;
                    end
                end else begin
                    // Timeout window keeps running across dropouts
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (w_locked_s) begin
                        stb_cnt_d = stb_cnt_q + STB_W'(1);
                    end else begin
                        state_d = WAIT_LOCK;
                    end
                end
            end
            RUN: begin
                if (w_loss) begin
                    lost_d  = 1'b1;
                    state_d = RESET_PLL;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase

        if (force_relock && state_q != RESET_PLL) begin
            state_d = RESET_PLL;
            retry_d = 2'd0;
        end

        if (state_d == RUN) begin
            retry_d = 2'd0;
        end

        // Entry edge counts as the first pulse cycle; after async reset the
        // counter starts at zero so the first edge after release is the entry
        if (state_d == RESET_PLL && state_q != RESET_PLL) begin
            rst_cnt_d = RST_W'(1);
            to_cnt_d  = '0;
        end
    end

    // FSM state and counter registers
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_PLL;
            rst_cnt_q <= '0;
            stb_cnt_q <= '0;
            to_cnt_q  <= '0;
            retry_q   <= 2'd0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            to_cnt_q  <= to_cnt_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
        end
    end

    // Registered outputs decoded from the next state
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pll_rst_q <= (state_d == RESET_PLL);
            sys_rst_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
            fault_q   <= (state_d == FAULT);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign lock_lost = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Directed self-checking bench for pll_lock_supervisor with
//               RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, MAX_RETRY=2.
//               Expectations for the RUN dropout step follow the
//               PLL_SUP_LOSS_FILTER_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic       lock_lost;

    int vectors     = 0;
    int miscompares = 0;

    pll_lock_supervisor #(
        .RST_CYCLES  (4),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(64),
        .MAX_RETRY   (2)
    ) u_dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fault       (fault),
        .retry_cnt   (retry_cnt),
        .lock_lost   (lock_lost)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_pll_rst"},   int'(pll_rst),   1);
        chk({tag, "_sys_rst"},   int'(sys_rst),   1);
        chk({tag, "_ready"},     int'(ready),     0);
        chk({tag, "_fault"},     int'(fault),     0);
        chk({tag, "_retry"},     int'(retry_cnt), 0);
        chk({tag, "_lock_lost"}, int'(lock_lost), 0);
    endtask

    // Called just after rst_n release: pll_rst must stay high through edges
    // 1..4 and fall on edge 5
    task automatic pulse_after_reset(input string tag);
        int hi;
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (pll_rst) hi++;
        end
        chk({tag, "_hi_cycles"}, hi, 4);
        chk({tag, "_pll_rst_fall"}, int'(pll_rst), 0);
        chk({tag, "_sys_rst"}, int'(sys_rst), 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        pll_locked   = 1'b0;
        force_relock = 1'b0;

        // Reset state
        tick(3);
        chk_rst_vals("por");

        // Power-up; lock arrives 10 cycles after pll_rst falls
        rst_n = 1'b1;
        pulse_after_reset("pu");
        tick(10);
        pll_locked = 1'b1;
        tick(10);
        chk("pu_ready_early", int'(ready), 0);
        tick(1);
        chk("pu_ready", int'(ready), 1);
        chk("pu_sys_rst", int'(sys_rst), 0);
        chk("pu_retry", int'(retry_cnt), 0);

        // Two-cycle lock dropout in RUN
        pll_locked = 1'b0;
        tick(2);
        chk("drop2_ready_pre", int'(ready), 1);
        pll_locked = 1'b1;
        tick(1);
`ifdef PLL_SUP_LOSS_FILTER_EN
        chk("drop2_ready_kept", int'(ready), 1);
        tick(3);
        chk("drop2_ready_later", int'(ready), 1);
        chk("drop2_no_lost", int'(lock_lost), 0);
        pll_locked = 1'b0;
        tick(5);
        pll_locked = 1'b1;
        tick(1);
        chk("drop5_ready_pre", int'(ready), 1);
        tick(1);
        chk("drop5_pll_rst", int'(pll_rst), 1);
        chk("drop5_ready", int'(ready), 0);
        chk("drop5_lost", int'(lock_lost), 1);
        chk("drop5_retry", int'(retry_cnt), 0);
`else
        chk("drop2_pll_rst", int'(pll_rst), 1);
        chk("drop2_ready", int'(ready), 0);
        chk("drop2_sys_rst", int'(sys_rst), 1);
        chk("drop2_lost", int'(lock_lost), 1);
        chk("drop2_retry", int'(retry_cnt), 0);
`endif

        // Lock never arrives: three pulses, then FAULT
        pll_locked = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_clears_lost", int'(lock_lost), 0);
        rst_n = 1'b1;
        pulse_after_reset("to");
        chk("to_retry0", int'(retry_cnt), 0);
        tick(63);
        chk("to1_pre_pll_rst", int'(pll_rst), 0);
        chk("to1_pre_retry", int'(retry_cnt), 0);
        tick(1);
        chk("to1_pll_rst", int'(pll_rst), 1);
        chk("to1_retry", int'(retry_cnt), 1);
        tick(3);
        chk("to1_pulse_hi", int'(pll_rst), 1);
        tick(1);
        chk("to1_pulse_fall", int'(pll_rst), 0);
        tick(64);
        chk("to2_pll_rst", int'(pll_rst), 1);
        chk("to2_retry", int'(retry_cnt), 2);
        tick(4);
        chk("to2_pulse_fall", int'(pll_rst), 0);
        tick(63);
        chk("to3_pre_fault", int'(fault), 0);
        tick(1);
        chk("to3_fault", int'(fault), 1);
        chk("to3_pll_rst", int'(pll_rst), 0);
        chk("to3_sys_rst", int'(sys_rst), 1);
        chk("to3_retry", int'(retry_cnt), 2);
        tick(10);
        chk("fault_held", int'(fault), 1);
        chk("fault_pll_rst_low", int'(pll_rst), 0);

        // force_relock from FAULT
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        chk("fr_fault", int'(fault), 0);
        chk("fr_retry", int'(retry_cnt), 0);
        chk("fr_pll_rst", int'(pll_rst), 1);
        chk("fr_sys_rst", int'(sys_rst), 1);
        tick(3);
        chk("fr_pulse_hi", int'(pll_rst), 1);
        tick(1);
        chk("fr_pulse_fall", int'(pll_rst), 0);

        // Lock right at release with a one-cycle dropout at stable count 5
        pll_locked = 1'b1;
        tick(6);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(10);
        chk("stb_drop_ready_late", int'(ready), 0);
        tick(1);
        chk("stb_drop_ready", int'(ready), 1);
        chk("stb_drop_sys_rst", int'(sys_rst), 0);

        // force_relock from RUN, then a late lock whose dropout pushes past the timeout
        pll_locked   = 1'b0;
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        chk("frun_pll_rst", int'(pll_rst), 1);
        chk("frun_sys_rst", int'(sys_rst), 1);
        chk("frun_ready", int'(ready), 0);
        chk("frun_no_lost", int'(lock_lost), 0);
        tick(4);
        chk("frun_pulse_fall", int'(pll_rst), 0);
        tick(50);
        pll_locked = 1'b1;
        tick(6);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(6);
        chk("win_pre_pll_rst", int'(pll_rst), 0);
        chk("win_pre_retry", int'(retry_cnt), 0);
        tick(1);
        chk("win_timeout_pll_rst", int'(pll_rst), 1);
        chk("win_timeout_retry", int'(retry_cnt), 1);
        chk("win_timeout_ready", int'(ready), 0);
        tick(4);
        chk("win_pulse_fall", int'(pll_rst), 0);
        tick(8);
        chk("win_ready_early", int'(ready), 0);
        chk("win_retry_kept", int'(retry_cnt), 1);
        tick(1);
        chk("win_ready", int'(ready), 1);
        chk("win_retry_clr", int'(retry_cnt), 0);

        // Asynchronous reset in the middle of STABLE
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        tick(4);
        chk("ar_pulse_fall", int'(pll_rst), 0);
        tick(3);
        #3;
        rst_n = 1'b0;
        #1;
        chk_rst_vals("ar");
        #2;
        rst_n = 1'b1;
        pulse_after_reset("ar_seq");
        tick(8);
        chk("ar_ready_early", int'(ready), 0);
        tick(1);
        chk("ar_ready", int'(ready), 1);
        chk("ar_sys_rst", int'(sys_rst), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
